// File: rtl/microcode_sequencer_if.sv
// Load/run bus of the microcode sequencer. The sequencer is the slave; the loader/CPU side is the master.
// When MICROCODE_PARITY_EN is defined, the bus also carries upar_err.
interface microcode_sequencer_if #(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned CTRL_W  = 15,
  parameter int unsigned OPC_W   = 6
);
  localparam int unsigned ADDR_W = (STATE_W > OPC_W) ? STATE_W : OPC_W;

  logic                stall;
  logic [OPC_W-1:0]    opcode;
  logic                ld_en;
  logic [1:0]          ld_sel;
  logic [ADDR_W-1:0]   ld_addr;
  logic [CTRL_W+1:0]   ld_data;
  logic [STATE_W-1:0]  state;
  logic [CTRL_W-1:0]   ctrl;
  logic [1:0]          addr_ctl;
  logic                held;
`ifdef MICROCODE_PARITY_EN
  logic                upar_err;
`endif

  modport master (
    output stall, opcode, ld_en, ld_sel, ld_addr, ld_data,
    input  state, ctrl, addr_ctl, held
`ifdef MICROCODE_PARITY_EN
    , input upar_err
`endif
  );

  modport slave (
    input  stall, opcode, ld_en, ld_sel, ld_addr, ld_data,
    output state, ctrl, addr_ctl, held
`ifdef MICROCODE_PARITY_EN
    , output upar_err
`endif
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microprogrammed control unit with writable microcode store and two opcode dispatch tables.
// Optional per-entry even parity with upar_err output: define MICROCODE_PARITY_EN.
module microcode_sequencer #(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned CTRL_W  = 15,
  parameter int unsigned OPC_W   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  microcode_sequencer_if.slave   bus
);
  localparam int unsigned WORD_W = CTRL_W + 2;
  localparam int unsigned DEPTH  = 1 << STATE_W;
  localparam int unsigned DISP_D = 1 << OPC_W;

  typedef enum logic [1:0] {
    AC_FETCH = 2'b00,
    AC_DISP1 = 2'b01,
    AC_DISP2 = 2'b10,
    AC_SEQ   = 2'b11
  } addr_ctl_e;

  typedef enum logic [1:0] {
    SEL_STORE = 2'b00,
    SEL_DISP1 = 2'b01,
    SEL_DISP2 = 2'b10,
    SEL_RSVD  = 2'b11
  } ld_sel_e;

  logic [WORD_W-1:0]  store [DEPTH];
  logic [STATE_W-1:0] disp1 [DISP_D];
  logic [STATE_W-1:0] disp2 [DISP_D];

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [WORD_W-1:0]  word;
  logic               advance;
  logic               wr_ok;
  addr_ctl_e          ac;

  // Asynchronous read of the current microinstruction
  assign word         = store[state_q];
  assign ac           = addr_ctl_e'(word[1:0]);
  assign bus.state    = state_q;
  assign bus.ctrl     = word[WORD_W-1:2];
  assign bus.addr_ctl = word[1:0];
  assign bus.held     = reset & (bus.stall | bus.ld_en);
  assign advance      = reset & ~bus.stall & ~bus.ld_en;
  assign wr_ok        = reset & bus.ld_en;

`ifdef MICROCODE_PARITY_EN
  logic par [DEPTH];
  logic par_err;

  // Even parity over word+parity bit must be zero for a clean entry
  assign par_err      = reset & ((^word) ^ par[state_q]);
  assign bus.upar_err = par_err;
`endif

  // Micro-state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next micro-state selection
  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (ac)
        AC_FETCH: state_d = '0;
        AC_DISP1: state_d = disp1[bus.opcode];
        AC_DISP2: state_d = disp2[bus.opcode];
        default:  state_d = state_q + STATE_W'(1);
      endcase
`ifdef MICROCODE_PARITY_EN
      if (par_err) begin
        state_d = '0;
      end
`endif
    end
  end

  // Store and dispatch table writes; contents survive reset, writes in reset cycles are dropped
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (ld_sel_e'(bus.ld_sel))
        SEL_STORE: begin
          store[bus.ld_addr[STATE_W-1:0]] <= bus.ld_data;
`ifdef MICROCODE_PARITY_EN
          par[bus.ld_addr[STATE_W-1:0]]   <= ^bus.ld_data;
`endif
        end
        SEL_DISP1: disp1[bus.ld_addr[OPC_W-1:0]] <= bus.ld_data[STATE_W-1:0];
        SEL_DISP2: disp2[bus.ld_addr[OPC_W-1:0]] <= bus.ld_data[STATE_W-1:0];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: vector table with hand-derived next states plus a
// scoreboard queue and a shadow copy of the loaded microcode for ctrl/addr_ctl expectations.
module tb_microcode_sequencer;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CTRL_W  = 15;
  localparam int unsigned OPC_W   = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  microcode_sequencer_if #(.STATE_W(STATE_W), .CTRL_W(CTRL_W), .OPC_W(OPC_W)) bus ();

  microcode_sequencer #(.STATE_W(STATE_W), .CTRL_W(CTRL_W), .OPC_W(OPC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ld;
    logic [1:0]  sel;
    logic [5:0]  op;
    logic [5:0]  addr;
    logic [16:0] data;
    logic [3:0]  nxt;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [16:0] m_store [16];
  bit          m_valid [16];
  logic [3:0]  cur;
  bit          cur_known = 1'b0;
  bit          exp_perr  = 1'b0;
  logic [3:0]  exp_q [$];
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic stall, input logic ld,
                              input logic [1:0] sel, input logic [5:0] op, input logic [5:0] addr,
                              input logic [16:0] data, input logic [3:0] nxt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ld = ld; v.sel = sel;
    v.op = op; v.addr = addr; v.data = data; v.nxt = nxt;
    return v;
  endfunction

  function automatic vec_t run(input logic [5:0] op, input logic [3:0] nxt);
    return mk(1'b1, 1'b0, 1'b0, 2'b00, op, 6'h00, 17'h0, nxt);
  endfunction

  function automatic vec_t load(input logic [1:0] sel, input logic [5:0] addr, input logic [16:0] data);
    return mk(1'b1, 1'b0, 1'b1, sel, 6'h00, addr, data, 4'h0);
  endfunction

  // One clock: drive, check combinational outputs, push expected state, compare after the edge
  task automatic step(input vec_t v, input string tag);
    logic [3:0] e;
    @(negedge clk);
    reset       = v.rst;
    bus.stall   = v.stall;
    bus.opcode  = v.op;
    bus.ld_en   = v.ld;
    bus.ld_sel  = v.sel;
    bus.ld_addr = v.addr;
    bus.ld_data = v.data;
    #1;
    chk({tag, " held"}, 32'(bus.held), 32'(v.rst & (v.stall | v.ld)));
    if (cur_known && m_valid[cur]) begin
      chk({tag, " ctrl"}, 32'(bus.ctrl), 32'(m_store[cur][16:2]));
      chk({tag, " addr_ctl"}, 32'(bus.addr_ctl), 32'(m_store[cur][1:0]));
`ifdef MICROCODE_PARITY_EN
      chk({tag, " upar_err"}, 32'(bus.upar_err), 32'(v.rst & exp_perr));
`endif
    end
    exp_q.push_back(v.nxt);
    if (v.rst && v.ld && v.sel == 2'b00) begin
      m_store[v.addr[3:0]] = v.data;
      m_valid[v.addr[3:0]] = 1'b1;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " state"}, 32'(bus.state), 32'(e));
    cur       = e;
    cur_known = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [14:0] c;
    logic [1:0]  a;

    reset       = 1'b0;
    bus.stall   = 1'b1;
    bus.opcode  = '0;
    bus.ld_en   = 1'b0;
    bus.ld_sel  = '0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

    step(mk(1'b0, 1'b1, 1'b0, 2'b00, 6'h00, 6'h00, 17'h0, 4'h0), "init_rst0");
    step(mk(1'b0, 1'b1, 1'b0, 2'b00, 6'h00, 6'h00, 17'h0, 4'h0), "init_rst1");

    // Preload: 0 seq, 1 disp1, 2 disp2, 5 fetch, all others sequential
    for (int i = 0; i < 16; i++) begin
      c = (i == 0) ? 15'h4401 : 15'(15'h0111 * i);
      a = (i == 1) ? 2'b01 : (i == 2) ? 2'b10 : (i == 5) ? 2'b00 : 2'b11;
      step(load(2'b00, 6'(i), {c, a}), "preload_store");
    end
    step(load(2'b01, 6'h23, 17'h2), "preload_d1_23");
    step(load(2'b01, 6'h10, 17'he), "preload_d1_10");
    step(load(2'b01, 6'h11, 17'h3), "preload_d1_11");
    step(load(2'b01, 6'h12, 17'h7), "preload_d1_12");
    step(load(2'b10, 6'h2B, 17'h5), "preload_d2_2b");

    tbl.push_back(run(6'h23, 4'h1));                                              // 0 -> 1 seq
    tbl.push_back(run(6'h23, 4'h2));                                              // disp1[23]
    tbl.push_back(run(6'h2B, 4'h5));                                              // disp2[2B]
    tbl.push_back(run(6'h2B, 4'h0));                                              // fetch
    tbl.push_back(run(6'h10, 4'h1));
    tbl.push_back(run(6'h10, 4'he));                                              // disp1[10]
    tbl.push_back(run(6'h23, 4'hf));                                              // opcode ignored
    tbl.push_back(run(6'h2B, 4'h0));                                              // 15 wraps to 0
    tbl.push_back(run(6'h11, 4'h1));
    tbl.push_back(run(6'h11, 4'h3));
    tbl.push_back(run(6'h3F, 4'h4));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 6'h23, 6'h00, 17'h0, 4'h4));        // stall x3
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 6'h23, 6'h00, 17'h0, 4'h4));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 6'h23, 6'h00, 17'h0, 4'h4));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 6'h00, 6'h04, {15'h7ABC, 2'b11}, 4'h4)); // rewrite current entry
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 2'b11, 6'h00, 6'h04, {15'h1234, 2'b00}, 4'h4)); // reserved target
    tbl.push_back(run(6'h00, 4'h5));
    tbl.push_back(run(6'h00, 4'h0));
    tbl.push_back(run(6'h12, 4'h1));
    tbl.push_back(run(6'h12, 4'h7));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 6'h00, 6'h03, {15'h5555, 2'b00}, 4'h0)); // reset beats load
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 6'h00, 6'h00, 17'h0, 4'h0));
    tbl.push_back(run(6'h11, 4'h1));
    tbl.push_back(run(6'h11, 4'h3));
    tbl.push_back(run(6'h00, 4'h4));                                              // store[3] kept old word

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Parity corner: corrupt entry 3 and expect a forced fetch
    step(run(6'h00, 4'h5), "par_walk0");
    step(run(6'h00, 4'h0), "par_walk1");
    step(run(6'h11, 4'h1), "par_walk2");
    step(run(6'h11, 4'h3), "par_walk3");
`ifdef MICROCODE_PARITY_EN
    dut.par[3] = ~dut.par[3];
    exp_perr   = 1'b1;
    step(run(6'h00, 4'h0), "par_err");
    dut.par[3] = ~dut.par[3];
    exp_perr   = 1'b0;
    step(run(6'h00, 4'h1), "par_clean");
`else
    step(run(6'h00, 4'h4), "no_par");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised microprogrammed control unit for the multicycle CPU.
- Holds the current micro-state in a register and a writable microcode store, replacing the fixed 16x17 microcode ROM.
- Holds two opcode dispatch tables and computes the next micro-state from a 2-bit address-control field.
- Outputs the control word for the datapath each cycle.

Parameters:
- STATE_W, 4, micro-state width; microcode store depth = 2**STATE_W.
- CTRL_W, 15, datapath control bits per microinstruction, excluding address control.
- OPC_W, 6, opcode width; each dispatch table depth = 2**OPC_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- stall  input  1  hold current micro-state (memory wait).
- opcode  input  OPC_W  instruction opcode from IR.
- ld_en  input  1  load strobe for microcode/dispatch write.
- ld_sel  input  2  00 = microcode store, 01 = dispatch 1, 10 = dispatch 2, 11 = reserved (write ignored).
- ld_addr  input  max(STATE_W,OPC_W)  write address; upper bits ignored for the narrower target.
- ld_data  input  CTRL_W+2  write data; dispatch writes use the low STATE_W bits.
- state  output  STATE_W  current micro-state register.
- ctrl  output  CTRL_W  control bits of the current microinstruction.
- addr_ctl  output  2  address-control field of the current microinstruction.
- held  output  1  1 when the state did not advance this cycle because of stall or ld_en.

Behaviour:
- Microinstruction layout: bits [CTRL_W+1:2] = ctrl, bits [1:0] = addr_ctl.
- Reads are asynchronous: ctrl and addr_ctl = store[state] in the same cycle.
- Reset (reset==0 at a clk edge): state <= 0. Store and dispatch contents are NOT cleared. Reset overrides stall and ld_en; a load write in the reset cycle is discarded.
- Next state, evaluated when reset==1, stall==0 and ld_en==0:
  - addr_ctl 00: state <= 0 (fetch).
  - addr_ctl 01: state <= disp1[opcode].
  - addr_ctl 10: state <= disp2[opcode].
  - addr_ctl 11: state <= state+1, modulo 2**STATE_W (all-ones wraps to 0).
- stall==1: state holds. ctrl remains the word at the held state.
- ld_en==1: the target entry is written at the clk edge and state holds that cycle (load has priority over advance).
  - A read of the entry being written in the same cycle returns old data; the new data is visible the next cycle.
  - ld_sel 11: no write, state still holds.
- held is combinational: = reset & (stall | ld_en). It is 0 during reset.
- Opcode is sampled only when the dispatch is taken at the clk edge; opcode changes in other cycles have no effect.
- Uninitialised store entries read X in simulation. Software must load every reachable entry before releasing stall.
- Classic MIPS micro-flow encoding: state 1 word ends with 01 (decode dispatch), state 2 word ends with 10 (mem-ref dispatch), sequential states use 11, final states use 00.

Optional Feature:
- Macro: MICROCODE_PARITY_EN.
- Defined:
  - Each store entry carries an extra even-parity bit, computed on write from ld_data.
  - New output upar_err (1 bit) = parity mismatch on the current entry.
  - When upar_err==1 and the sequencer would otherwise advance, state <= 0 instead of the computed next state.
  - upar_err resets to 0.
- Undefined: no parity storage, no upar_err port, next state unchanged.

Test Plan:
- Reset with reset=0 for 2 cycles mid-run from state 7 -> state==0 after the first edge; a simultaneous ld_en write to store[3] is discarded, and store[3] reads old data afterwards.
- Load store[0]={ctrl=15'h4401, ac=11}, store[1]={ac=01}, disp1[6'h23]=4'h2, then run with opcode=6'h23 -> state sequence 0,1,2; ctrl at state 0 = 15'h4401; held==1 during each load cycle.
- Dispatch 2: store[2] ac=10, disp2[6'h2B]=4'h5, opcode=6'h2B -> state 5 the cycle after state 2; store[5] ac=00 -> state 0 next.
- Wrap: store[15] ac=11 -> state 15 to 0; stall=1 for 3 cycles at state 4 -> state stays 4, held==1, ctrl stable.
- Write store[4] while state==4 -> same-cycle ctrl shows old value, next cycle shows new value; ld_sel=11 write changes nothing.
- With MICROCODE_PARITY_EN defined: force a corrupted entry at state 3 via hierarchical deposit -> upar_err==1, next state 0; without the macro, upar_err is absent and the port list matches the base design.
